// File: rtl/seq_gen_pkg.sv
// ---------------------------------------------------------------------------
// seq_gen_pkg
// Shared definitions for the serial pattern generator:
//   - state_e   : two-state FSM encoding (IDLE, SHIFT)
//   - clamp_len : maps a requested length onto the effective length
//                 (0 or anything above the pattern width means "full width")
// ---------------------------------------------------------------------------
package seq_gen_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // A request of 0 bits, or more bits than the pattern holds, sends the
  // whole pattern.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned width);
    if ((len == 0) || (len > width)) begin
      return width;
    end
    return len;
  endfunction

endpackage

// File: rtl/seq_gen_tick.sv
// ---------------------------------------------------------------------------
// seq_gen_tick
// Bit-period counter. Counts enabled cycles and raises tick in the last
// enabled cycle of every BIT_CYCLES-long period.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears the counter
//   load  : restart the period count from zero
//   en    : count this cycle
//   tick  : high in the final cycle of a bit period (while en is high)
// ---------------------------------------------------------------------------
module seq_gen_tick #(
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    tick  = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en) begin
      // Wrap at the end of each period so back-to-back bits need no reload.
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_gen.sv
// ---------------------------------------------------------------------------
// seq_gen
// Serialises a parallel bit pattern, MSB (bit len-1) first, holding each bit
// for BIT_CYCLES clocks. Intended to drive a sequence detector under test.
//
// Parameters:
//   WIDTH      : maximum pattern length in bits
//   BIT_CYCLES : clocks each serial bit is held
//   LEN_W      : width of the length field
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   in_valid     : pattern request presented
//   in_ready     : request can be accepted this cycle (combinational)
//   in_pattern   : bits to send
//   in_len       : number of bits to send (0 or > WIDTH means WIDTH)
//   abort        : cancel the transfer in progress / block acceptance
//   repeat_en    : only with SEQ_GEN_REPEAT_EN defined; when high at the end
//                  of the last bit period the pattern restarts with no gap
//                  ("repeat" itself is a reserved word, hence the name)
//   serial_out   : serial bit, 0 whenever serial_valid is low
//   serial_valid : serial_out carries a pattern bit
//   busy         : FSM is in SHIFT
//   done         : one-cycle pulse at pattern completion
//
// Build option: define SEQ_GEN_REPEAT_EN to add the repeat_en input.
// ---------------------------------------------------------------------------
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned BIT_CYCLES = 1,
  parameter int unsigned LEN_W      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pattern,
  input  logic [LEN_W-1:0] in_len,
  input  logic             abort,
`ifdef SEQ_GEN_REPEAT_EN
  input  logic             repeat_en,
`endif
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] pattern_q;
  logic [WIDTH-1:0] pattern_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic             serial_out_q;
  logic             serial_out_d;
  logic             serial_valid_q;
  logic             serial_valid_d;
  logic             busy_q;
  logic             busy_d;
  logic             done_q;
  logic             done_d;

  logic             handshake;
  logic             tick;
  logic             tick_en;
  logic             rep_now;
  logic             last_bit;
  logic [31:0]      eff_len_w;
  logic [LEN_W-1:0] eff_len;
  logic [IDX_W-1:0] eff_idx;
  logic [IDX_W-1:0] nxt_idx;
  logic [IDX_W-1:0] restart_idx;

`ifdef SEQ_GEN_REPEAT_EN
  assign rep_now = repeat_en;
`else
  assign rep_now = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE) && !abort;
  assign handshake = in_valid && in_ready;

  assign eff_len_w   = clamp_len(32'(in_len), WIDTH);
  assign eff_len     = LEN_W'(eff_len_w);
  assign eff_idx     = IDX_W'(eff_len_w - 32'd1);
  assign nxt_idx     = idx_q - 1'b1;
  assign restart_idx = IDX_W'(len_q - 1'b1);

  // The counter runs only while shifting; abort stops it so a cancelled
  // transfer can never produce a late tick.
  assign tick_en  = (state_q == SHIFT) && !abort;
  assign last_bit = tick && (idx_q == '0);

  seq_gen_tick #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .load (handshake),
    .en   (tick_en),
    .tick (tick)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (last_bit && !rep_now) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values. All outputs except in_ready are taken
  // from registers, so the first bit is computed here from the request
  // itself to appear one cycle after the handshake.
  always_comb begin
    pattern_d      = pattern_q;
    len_d          = len_q;
    idx_d          = idx_q;
    serial_out_d   = 1'b0;
    serial_valid_d = 1'b0;
    done_d         = 1'b0;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          pattern_d      = in_pattern;
          len_d          = eff_len;
          idx_d          = eff_idx;
          serial_out_d   = in_pattern[eff_idx];
          serial_valid_d = 1'b1;
        end
      end
      SHIFT: begin
        if (abort) begin
          idx_d = '0;
        end else if (last_bit) begin
          done_d = 1'b1;
          if (rep_now) begin
            idx_d          = restart_idx;
            serial_out_d   = pattern_q[restart_idx];
            serial_valid_d = 1'b1;
          end
        end else if (tick) begin
          idx_d          = nxt_idx;
          serial_out_d   = pattern_q[nxt_idx];
          serial_valid_d = 1'b1;
        end else begin
          serial_out_d   = serial_out_q;
          serial_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q      <= '0;
      len_q          <= '0;
      idx_q          <= '0;
      serial_out_q   <= 1'b0;
      serial_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      pattern_q      <= pattern_d;
      len_q          <= len_d;
      idx_q          <= idx_d;
      serial_out_q   <= serial_out_d;
      serial_valid_q <= serial_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign serial_out   = serial_out_q;
  assign serial_valid = serial_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
